// File: rtl/req_ack_4phase_arbiter.sv
// rtl/req_ack_4phase_arbiter.sv - round-robin arbiter sharing one 4-phase req/ack crossing channel
//
// Ports:
//   clk1      sending-domain clock
//   rst1_n    synchronous active-low reset
//   up_valid  per-requester valid (NREQ)
//   up_ready  per-requester ready, one-hot or zero (NREQ)
//   up_data   packed requester data, requester i at [i*DWIDTH +: DWIDTH]
//   req       4-phase request to the far domain (registered)
//   ack       4-phase acknowledge, already synchronized into clk1
//   dout      captured data, stable while req or ack is high
//   dout_id   index of the requester owning dout
//   busy      high whenever the FSM is not idle
//   xfer_cnt  completed-handshake counter, wraps silently
module req_ack_4phase_arbiter #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 8,
    parameter int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1,
    parameter int CNTW   = 16
) (
    input  logic                   clk1,
    input  logic                   rst1_n,
    input  logic [NREQ-1:0]        up_valid,
    output logic [NREQ-1:0]        up_ready,
    input  logic [NREQ*DWIDTH-1:0] up_data,
    output logic                   req,
    input  logic                   ack,
    output logic [DWIDTH-1:0]      dout,
    output logic [IDW-1:0]         dout_id,
    output logic                   busy,
    output logic [CNTW-1:0]        xfer_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_REL
    } state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant;
    logic           found;
    logic           accept;
    logic [IDW-1:0] next_ptr;

    // Search starts at rr_ptr so the most recent winner has lowest priority.
    always_comb begin
        int idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && up_valid[idx]) begin
                found = 1'b1;
                grant = IDW'(idx);
            end
        end
    end

    // No grant while the far side still holds ack from an abandoned transfer.
    assign accept   = (state == ST_IDLE) && !ack && found;
    assign up_ready = accept ? (NREQ'(1) << grant) : '0;
    assign busy     = (state != ST_IDLE);
    assign next_ptr = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);

    always_ff @(posedge clk1) begin
        if (!rst1_n) begin
            state    <= ST_IDLE;
            req      <= 1'b0;
            dout     <= '0;
            dout_id  <= '0;
            rr_ptr   <= '0;
            xfer_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        dout    <= up_data[int'(grant)*DWIDTH +: DWIDTH];
                        dout_id <= grant;
                        rr_ptr  <= next_ptr;
                        req     <= 1'b1;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ack) begin
                        req   <= 1'b0;
                        state <= ST_REL;
                    end
                end
                ST_REL: begin
                    if (!ack) begin
                        xfer_cnt <= xfer_cnt + CNTW'(1);
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    req   <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req_ack_4phase_arbiter.sv
// tb/tb_req_ack_4phase_arbiter.sv - directed-vector bench for req_ack_4phase_arbiter
module tb_req_ack_4phase_arbiter;

    localparam int NREQ   = 4;
    localparam int DWIDTH = 8;
    localparam int IDW    = 2;
    localparam int CNTW   = 4;

    logic                   clk1;
    logic                   rst1_n;
    logic [NREQ-1:0]        up_valid;
    logic [NREQ-1:0]        up_ready;
    logic [NREQ*DWIDTH-1:0] up_data;
    logic                   req;
    logic                   ack;
    logic [DWIDTH-1:0]      dout;
    logic [IDW-1:0]         dout_id;
    logic                   busy;
    logic [CNTW-1:0]        xfer_cnt;

    int n_vec;
    int n_err;

    req_ack_4phase_arbiter #(
        .NREQ   (NREQ),
        .DWIDTH (DWIDTH),
        .CNTW   (CNTW)
    ) dut (
        .clk1     (clk1),
        .rst1_n   (rst1_n),
        .up_valid (up_valid),
        .up_ready (up_ready),
        .up_data  (up_data),
        .req      (req),
        .ack      (ack),
        .dout     (dout),
        .dout_id  (dout_id),
        .busy     (busy),
        .xfer_cnt (xfer_cnt)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    // One full handshake with ack answering on the edge after each req change.
    task automatic do_xfer(input int exp_id, input logic [7:0] exp_data, input logic [3:0] exp_cnt);
        @(negedge clk1);
        check("idle_ready", 32'(up_ready), 32'(4'b0001 << exp_id));
        check("idle_busy", 32'(busy), 0);
        step();
        check("req_high", 32'(req), 1);
        check("dout", 32'(dout), 32'(exp_data));
        check("dout_id", 32'(dout_id), 32'(exp_id));
        check("req_ready", 32'(up_ready), 0);
        check("req_busy", 32'(busy), 1);
        ack = 1'b1;
        step();
        check("rel_req_low", 32'(req), 0);
        check("rel_ready", 32'(up_ready), 0);
        ack = 1'b0;
        step();
        check("xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
        check("done_busy", 32'(busy), 0);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst1_n   = 1'b0;
        ack      = 1'b0;
        up_valid = '0;
        for (int i = 0; i < NREQ; i++) up_data[i*DWIDTH +: DWIDTH] = 8'h10 + 8'(i);
        step();
        step();
        check("rst_req", 32'(req), 0);
        check("rst_dout", 32'(dout), 0);
        check("rst_id", 32'(dout_id), 0);
        check("rst_cnt", 32'(xfer_cnt), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(up_ready), 0);
        rst1_n = 1'b1;
        step();

        // round robin from rr_ptr=0 with all valid
        up_valid = 4'b1111;
        do_xfer(0, 8'h10, 4'd1);
        do_xfer(1, 8'h11, 4'd2);
        do_xfer(2, 8'h12, 4'd3);
        do_xfer(3, 8'h13, 4'd4);
        do_xfer(0, 8'h10, 4'd5);
        up_valid = '0;
        step();
        check("rr_quiet_busy", 32'(busy), 0);

        // single requester 2
        up_data[2*DWIDTH +: DWIDTH] = 8'hA5;
        up_valid = 4'b0100;
        do_xfer(2, 8'hA5, 4'd6);
        up_valid = '0;
        up_data[2*DWIDTH +: DWIDTH] = 8'h12;
        step();
        check("single_busy", 32'(busy), 0);

        // rr_ptr=3 now: pointer wraps to 0, requester 3 never readied
        up_valid = 4'b0011;
        do_xfer(0, 8'h10, 4'd7);
        do_xfer(1, 8'h11, 4'd8);
        do_xfer(0, 8'h10, 4'd9);
        up_valid = '0;
        step();

        // slow ack; rr_ptr=1, only requester 3 valid at acceptance
        up_valid = 4'b1000;
        @(negedge clk1);
        check("slow_ready", 32'(up_ready), 32'(4'b1000));
        step();
        up_valid = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            check("slow_req_hold", 32'(req), 1);
            check("slow_dout", 32'(dout), 32'h13);
            check("slow_ready_req", 32'(up_ready), 0);
            step();
        end
        ack = 1'b1;
        step();
        for (int i = 0; i < 15; i++) begin
            check("slow_rel_req", 32'(req), 0);
            check("slow_rel_dout", 32'(dout), 32'h13);
            check("slow_rel_id", 32'(dout_id), 3);
            check("slow_rel_ready", 32'(up_ready), 0);
            check("slow_rel_cnt", 32'(xfer_cnt), 9);
            step();
        end
        ack = 1'b0;
        step();
        up_valid = '0;
        check("slow_cnt", 32'(xfer_cnt), 10);
        check("slow_busy", 32'(busy), 0);
        step();

        // counter wrap on the 16th transfer; rr_ptr=0
        up_valid = 4'b0001;
        do_xfer(0, 8'h10, 4'd11);
        do_xfer(0, 8'h10, 4'd12);
        do_xfer(0, 8'h10, 4'd13);
        do_xfer(0, 8'h10, 4'd14);
        do_xfer(0, 8'h10, 4'd15);
        do_xfer(0, 8'h10, 4'd0);
        up_valid = '0;
        step();
        check("wrap_busy", 32'(busy), 0);
        check("wrap_req", 32'(req), 0);

        // reset while in REQ with ack held high afterwards
        up_valid = 4'b0010;
        @(negedge clk1);
        check("mid_ready", 32'(up_ready), 32'(4'b0010));
        step();
        check("mid_req", 32'(req), 1);
        ack    = 1'b1;
        rst1_n = 1'b0;
        step();
        rst1_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("mid_rst_req", 32'(req), 0);
            check("mid_rst_cnt", 32'(xfer_cnt), 0);
            check("mid_rst_dout", 32'(dout), 0);
            check("mid_rst_busy", 32'(busy), 0);
            check("mid_rst_ready", 32'(up_ready), 0);
            step();
        end
        ack = 1'b0;
        do_xfer(1, 8'h11, 4'd1);
        up_valid = '0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
